// File: rtl/aes_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_uart_pkg
// Brief  : Shared command bytes, error codes, controller state encoding and
//          the inter-byte timeout derivation for the UART-to-AES front end.
// Rev    : 1.0  initial release
// ============================================================================
package aes_uart_pkg;

  // Frame command bytes
  localparam logic [7:0] CMD_KEY = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_PT  = 8'h50;  // 'P'

  // Error causes reported on err_code
  typedef enum logic [1:0] {
    ERR_BAD_CMD = 2'd0,
    ERR_NO_KEY  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One character is 10 bit times (start + 8 data + stop).
  function automatic int unsigned timeout_clks(input int unsigned clk_freq,
                                               input int unsigned baudrate,
                                               input int unsigned timeout_bytes);
    return timeout_bytes * 10 * (clk_freq / baudrate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module : rx_timeout_timer
// Brief  : Idle counter for the inter-byte timeout. Counts enabled cycles
//          since the last clear and flags the cycle in which the next edge
//          is the TIMEOUT_CLKS-th one.
// Ports  : clk     - system clock
//          rst_n   - asynchronous active-low reset
//          clear   - restart the count (accepted byte or controller idle)
//          enable  - count while a frame is being received
//          expired - high when the coming edge completes TIMEOUT_CLKS cycles
// Rev    : 1.0  initial release
// ============================================================================
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CLKS = 34_720
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CLKS + 1);
  // The clear edge leaves the count at 0, so after N idle edges it holds N;
  // the abort edge is the one where the count already reads TIMEOUT_CLKS-1.
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/aes_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes_rx_ctrl
// Brief  : Byte-level frame controller between uart_rx and the AES core.
//          Parses 'K'/'P' command-prefixed 16-byte frames into a 128-bit key
//          or plaintext block, hands plaintext over valid/ready, and reports
//          bad commands, missing key, inter-byte timeout and overrun.
// Ports  : clk, rst_n     - clock, asynchronous active-low reset
//          rx_data/rx_done - byte and one-cycle strobe from uart_rx
//          key_out/key_valid/key_loaded - latest key, update pulse, key seen
//          block_out/block_valid/block_ready - plaintext handshake
//          busy           - controller outside IDLE
//          err/err_code   - error pulse and held cause
// Rev    : 1.0  initial release
// ============================================================================
module aes_rx_ctrl
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned BAUDRATE      = 115_200,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic         key_loaded,
  output logic [127:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int unsigned TIMEOUT_CLKS =
    timeout_clks(CLK_FREQ, BAUDRATE, TIMEOUT_BYTES);

  state_t         state;
  logic [3:0]     cnt;
  logic [127:0]   shreg;
  logic           in_frame;
  logic           tmr_clear;
  logic           tmr_expired;

  // The timer only runs while a frame is being assembled; any accepted byte
  // (the command byte is accepted in IDLE, where the timer is held clear)
  // restarts it.
  assign in_frame  = (state == ST_KEY) || (state == ST_DATA);
  assign tmr_clear = rx_done || !in_frame;

  rx_timeout_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (in_frame),
    .expired (tmr_expired)
  );

  // The shift register doubles as the plaintext output; it is frozen in HOLD
  // because bytes arriving there are dropped.
  assign block_out = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      shreg       <= '0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      key_loaded  <= 1'b0;
      block_valid <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      key_valid <= 1'b0;
      err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            if (rx_data == CMD_KEY) begin
              state <= ST_KEY;
              cnt   <= 4'd0;
              busy  <= 1'b1;
            end else if (rx_data == CMD_PT) begin
              if (key_loaded) begin
                state <= ST_DATA;
                cnt   <= 4'd0;
                busy  <= 1'b1;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_NO_KEY;
              end
            end else begin
              err      <= 1'b1;
              err_code <= ERR_BAD_CMD;
            end
          end
        end

        ST_KEY, ST_DATA: begin
          // A byte on the expiry edge wins over the timeout.
          if (rx_done) begin
            shreg <= {shreg[119:0], rx_data};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              if (state == ST_KEY) begin
                key_out    <= {shreg[119:0], rx_data};
                key_valid  <= 1'b1;
                key_loaded <= 1'b1;
                state      <= ST_IDLE;
                busy       <= 1'b0;
              end else begin
                block_valid <= 1'b1;
                state       <= ST_HOLD;
              end
            end
          end else if (tmr_expired) begin
            // Partial frames are abandoned; key_out/key_loaded untouched.
            state    <= ST_IDLE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        ST_HOLD: begin
          // Overrun is flagged even if the handshake completes this edge.
          if (rx_done) begin
            err      <= 1'b1;
            err_code <= ERR_OVERRUN;
          end
          if (block_valid && block_ready) begin
            block_valid <= 1'b0;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/aes_rx_ctrl.md
# aes_rx_ctrl

Byte-level frame controller between `uart_rx` and the AES core. It consumes the one-cycle `data_out`/`data_out_done` byte strobes and parses command-prefixed 16-byte frames. It assembles each frame into a 128-bit key or plaintext block and presents plaintext to the encryption core over a valid/ready handshake. It enforces an inter-byte timeout and reports framing errors, so a corrupted host stream can never leave the AES datapath half-loaded.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `BAUDRATE`, default 115_200: UART rate in baud. `BIT_CLKS = CLK_FREQ/BAUDRATE`.
- `TIMEOUT_BYTES`, default 4: abort threshold in character times. `TIMEOUT_CLKS = TIMEOUT_BYTES*10*BIT_CLKS`, which is 34_720 at the defaults.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: byte from `uart_rx` `data_out`.
- `rx_done` input 1: one-cycle strobe from `uart_rx` `data_out_done`.
- `key_out` output 128: last fully received key.
- `key_valid` output 1: one-cycle pulse when `key_out` is updated.
- `key_loaded` output 1: high once any key has completed since reset.
- `block_out` output 128: assembled plaintext block.
- `block_valid` output 1: plaintext available.
- `block_ready` input 1: AES core accepts the block.
- `busy` output 1: high in any state other than IDLE.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: error cause, valid when `err` is high and held until the next `err`.

## Operation
- Frame format: one command byte followed by 16 data bytes.
  - Command 0x4B ('K') loads a key.
  - Command 0x50 ('P') loads a plaintext block.
- Byte order: the first data byte lands in bits [127:120] and the last in [7:0] (FIPS-197 order). Assembly uses a 128-bit left-shift register shared by both frame types, with byte counter `cnt` [3:0].
- States:
  - IDLE. On `rx_done`:
    - 'K': go to KEY, `cnt`=0.
    - 'P' with `key_loaded`=1: go to DATA, `cnt`=0.
    - 'P' with `key_loaded`=0: `err`, code NO_KEY, stay in IDLE.
    - Any other byte: `err`, code BAD_CMD, stay in IDLE.
  - KEY and DATA: each `rx_done` shifts in `rx_data` and increments `cnt`.
    - On the 16th byte (`cnt`=15), KEY copies the completed word to `key_out`, sets `key_valid` and `key_loaded`, and returns to IDLE.
    - On the 16th byte, DATA sets `block_valid` and goes to HOLD.
  - HOLD: `block_out` (the shift register) is held stable. On an edge with `block_valid & block_ready`, `block_valid` clears and the state returns to IDLE.
- Timeout: in KEY or DATA, an idle counter clears on every accepted byte (including the command byte). If it reaches `TIMEOUT_CLKS` without `rx_done`, the controller aborts to IDLE with `err`, code TIMEOUT. A partial key never reaches `key_out`, and `key_loaded` is unchanged.
- Overrun: any `rx_done` in HOLD drops the byte and raises `err` with code OVERRUN. This applies even when the handshake completes on the same edge.
- Error codes: 0 BAD_CMD, 1 NO_KEY, 2 TIMEOUT, 3 OVERRUN.
- A new key frame may be received while no block is pending. The next 'P' frame uses the new key.

## Timing
- Reset values: all registers 0 and state IDLE. That gives `key_out`=0, `block_out`=0, `key_valid`=0, `key_loaded`=0, `block_valid`=0, `busy`=0, `err`=0, `err_code`=0.
- Asserting `rst_n` low mid-frame or in HOLD discards everything, including the stored key.
- `key_valid`, `block_valid` and `err` rise one clock after the edge that samples the triggering `rx_done`. They are registered outputs.
- `block_valid` stays high until the accepting edge and is low in the following cycle. Minimum HOLD residence is 1 cycle.
- `busy` rises one cycle after the command byte's `rx_done` and falls in the cycle after the return to IDLE.
- The timeout fires on exactly the `TIMEOUT_CLKS`-th cycle after the last accepted `rx_done`. An `rx_done` on that same edge wins: the byte is accepted and there is no error.
- `rx_done` is assumed to be at most one pulse per `BIT_CLKS*10` cycles. The block has no back-pressure to `uart_rx`.

## Structure
- Package `aes_uart_pkg` holds:
  - the command constants `CMD_KEY`=8'h4B and `CMD_PT`=8'h50;
  - the error-code constants;
  - the state encoding (IDLE, KEY, DATA, HOLD);
  - the `TIMEOUT_CLKS` derivation function.
- One sub-module, `rx_timeout_timer`, implements the idle counter. Its ports are clear, enable and expired, and its width is `$clog2(TIMEOUT_CLKS+1)`.

## Test plan
- Run the bench with `TIMEOUT_BYTES`=2 and serial bytes driven through a real `uart_rx` instance.
- Send 'K' then 00..0F → `key_valid` pulses once, `key_out`=128'h000102030405060708090A0B0C0D0E0F, `key_loaded`=1, `busy` returns to 0.
- Send 'P' before any key → `err`=1 with `err_code`=1 and no `block_valid`. Send 0x33 → `err_code`=0.
- With a key loaded, send 'P' then 16×0xA5 while holding `block_ready`=0 → `block_valid` stays high and `block_out`=all A5. Send a 0x55 byte → `err_code`=3 and `block_out` is unchanged. Pulse `block_ready` → `block_valid` falls the next cycle.
- Send 'K' plus 7 bytes, then go silent → `err_code`=2 exactly `TIMEOUT_CLKS` cycles after the 7th `rx_done`, and `key_out` keeps its previous value.
- Assert `rst_n` low after 10 plaintext bytes → all outputs 0. Then send a full 'P' frame → `err_code`=1, because the key was cleared by reset.
- Hold `block_ready`=1 constantly and send a 'P' frame → `block_valid` is high for exactly 1 cycle.
